processing_element_ms: RTL and testbench
========================================

Name: processing_element_ms

Overview:
- Next-generation systolic processing element with run-time dataflow mode: output-stationary (OS) or weight-stationary (WS).
- Adds a parametrised multiplier pipeline, valid tracking, stationary-weight preload, and a double-buffered OS drain chain.
- One instance per array cell; act flows east, wei flows south, and partial sums or drained results flow along the MAC chain.

Parameters:
- WIDTH_A, 16, activation width
- WIDTH_B, 16, weight width
- WIDTH_MAC, 48, accumulator/partial-sum width; must be >= WIDTH_A+WIDTH_B
- MUL_STAGE, 2, multiplier pipeline depth including the operand register; must be >= 1
- SIGNED, 0, 1 = two's-complement operands and accumulator, 0 = unsigned

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- mode  in  1  0 = OS, 1 = WS; sampled only in IDLE
- pipeline_en  in  1  global advance; 0 = every register holds
- reg_clear  in  1  synchronous clear of all data, valids and state
- act / act_valid  in  WIDTH_A / 1  activation and its qualifier
- wei / wei_valid  in  WIDTH_B / 1  weight and its qualifier
- preload  in  1  WS: capture wei into the stationary register
- c_switch  in  1  OS: move accumulator into the drain shadow register
- cscan_en  in  1  OS: shift shadow chain (shadow <= MAC_IN)
- MAC_IN / MAC_in_valid  in  WIDTH_MAC / 1  upstream partial sum or scan data
- act_out / act_valid_out  out  WIDTH_A / 1  act forwarded with 1-cycle delay
- wei_out / wei_valid_out  out  WIDTH_B / 1  wei forwarded with 1-cycle delay
- c_switch_out  out  1  c_switch delayed 1 cycle
- MAC_out / MAC_valid_out  out  WIDTH_MAC / 1  OS: shadow register; WS: registered partial sum
- busy  out  1  state != IDLE, or any valid in the multiplier pipe

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: every output and internal register is 0 and the state is IDLE.
- reg_clear: produces the same result as reset, at the next edge; it overrides pipeline_en.
- pipeline_en=0: all registers, including state, hold their value; the registered outputs are frozen.
- State machine: IDLE, OS_RUN, WS_LOAD, WS_RUN.
  - IDLE with mode=0 and act_valid&wei_valid -> OS_RUN.
  - IDLE with mode=1 and preload -> WS_LOAD.
  - WS_LOAD -> WS_RUN unconditionally after 1 cycle.
  - WS_RUN with preload -> WS_LOAD.
  - OS_RUN and WS_RUN leave only via reg_clear or reset.
  - mode is ignored outside IDLE.
- Product issue:
  - OS: issues when act_valid&wei_valid.
  - WS: issues when act_valid, using the stationary weight.
  - Operands sampled at edge k reach acc/psum at edge k+MUL_STAGE.
- Width rule:
  - Product is WIDTH_A+WIDTH_B bits, sign- or zero-extended to WIDTH_MAC.
  - Addition wraps modulo 2^WIDTH_MAC unless the optional feature is enabled.
- OS datapath:
  - acc += product for each valid product.
  - On c_switch: shadow <= acc + (in-flight product landing that edge), acc <= 0, shadow_valid <= 1.
  - On cscan_en: shadow <= MAC_IN, shadow_valid <= MAC_in_valid.
  - c_switch and cscan_en in the same cycle: c_switch wins.
  - MAC_out = shadow; MAC_valid_out = shadow_valid.
- WS datapath:
  - MAC_IN and MAC_in_valid are delayed MUL_STAGE-1 cycles to align with the product.
  - psum <= MAC_IN_aligned + product; MAC_valid_out = product valid.
  - preload in the same cycle as act_valid: that act uses the old weight; the new weight applies from the next cycle.
  - wei_out forwards wei in both modes, so a column preloads serially.
- Forwarding: act_out, wei_out and c_switch_out are 1-cycle registered copies, and are stalled by pipeline_en.
- Reset asserted mid-pipe: in-flight products are discarded; no partial result is emitted.

Optional Feature:
- Macro PE_MAC_SATURATE_EN.
- Defined: the accumulate/psum adder saturates instead of wrapping.
  - Unsigned: clamps to 2^WIDTH_MAC-1.
  - Signed: clamps to the max positive or min negative value.
- Undefined: modulo wrap, with no extra logic.

Decomposition:
- Package pe_ms_pkg holds:
  - state enum (IDLE/OS_RUN/WS_LOAD/WS_RUN);
  - mode enum (MODE_OS/MODE_WS);
  - saturating-add function, parametrised by width and signedness.
- Sub-module pe_mult_pipe: a MUL_STAGE-deep multiplier with a valid pipe and stall input. It is instantiated once.

Test Plan:
- Reset mid-OS accumulation: drop rst_n between edges -> all outputs 0 immediately; busy=0; state IDLE.
- OS, MUL_STAGE=2: act=1,2,3,4 with wei=2 on consecutive cycles, then c_switch -> MAC_out=0x14, MAC_valid_out=1, c_switch_out high 1 cycle later; next product accumulates from 0.
- OS scan: shadow=0x14, MAC_IN=0xABC, MAC_in_valid=1, cscan_en 1 cycle -> MAC_out=0xABC; c_switch and cscan_en asserted together -> shadow takes acc.
- WS: preload wei=3, then act=5 with MAC_IN=100 -> MAC_out=115 after 2 edges. Second preload wei=7 concurrent with act=5 -> that output uses weight 3, the following act=5 uses 7.
- Stall: pipeline_en=0 for 3 cycles mid-OS-stream -> outputs frozen; final MAC_out identical to an unstalled run (0x14).
- Overflow, WS, unsigned: MAC_IN=0xFFFF_FFFF_FFFE, act=2, wei=2 -> MAC_out=0x2 without the macro, 0xFFFF_FFFF_FFFF with PE_MAC_SATURATE_EN.

Source files
------------

// File: rtl/pe_ms_pkg.sv
// ============================================================================
// Module      : pe_ms_pkg
// Description : Shared types and helpers for the multi-mode systolic PE.
//               - state encoding (IDLE / OS_RUN / WS_LOAD / WS_RUN)
//               - dataflow mode encoding (MODE_OS / MODE_WS)
//               - sat_add(): width/signedness-parametrised saturating adder
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pe_ms_pkg;

    typedef logic [1:0] pe_state_t;
    localparam pe_state_t c_ST_IDLE    = 2'd0;
    localparam pe_state_t c_ST_OS_RUN  = 2'd1;
    localparam pe_state_t c_ST_WS_LOAD = 2'd2;
    localparam pe_state_t c_ST_WS_RUN  = 2'd3;

    typedef logic pe_mode_t;
    localparam pe_mode_t c_MODE_OS = 1'b0;
    localparam pe_mode_t c_MODE_WS = 1'b1;

    // Widest operand sat_add() handles; 'width' must be strictly below this.
    localparam int c_SAT_MAXW = 128;

    // Saturating add of two 'width'-bit values carried zero-extended in a
    // c_SAT_MAXW container. Result is returned zero-extended the same way.
    function automatic logic [c_SAT_MAXW-1:0] sat_add(
        input logic [c_SAT_MAXW-1:0] a,
        input logic [c_SAT_MAXW-1:0] b,
        input int                    width,
        input logic                  is_signed
    );
        logic [c_SAT_MAXW-1:0] one;
        logic [c_SAT_MAXW-1:0] mask;
        logic [c_SAT_MAXW-1:0] maxp;
        logic [c_SAT_MAXW-1:0] sum;
        logic [c_SAT_MAXW-1:0] res;
        logic [c_SAT_MAXW-1:0] tmp;
        logic                  carry;
        logic                  sa;
        logic                  sb;
        logic                  ss;
        one   = c_SAT_MAXW'(1);
        mask  = (one << width) - one;
        sum   = (a & mask) + (b & mask);
        tmp   = sum >> width;
        carry = tmp[0];
        tmp   = a >> (width - 1);
        sa    = tmp[0];
        tmp   = b >> (width - 1);
        sb    = tmp[0];
        tmp   = sum >> (width - 1);
        ss    = tmp[0];
        maxp  = mask >> 1;
        res   = sum & mask;
        if (!is_signed) begin
            if (carry) res = mask;
        end else if ((sa == sb) && (ss != sa)) begin
            // Same-sign operands produced an opposite-sign result.
            res = sa ? (mask & ~maxp) : maxp;
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pe_mult_pipe.sv
// ============================================================================
// Module      : pe_mult_pipe
// Description : MUL_STAGE-deep multiplier with valid/tag tracking and stall.
//               Stage 1 is the operand register; the remaining MUL_STAGE-1
//               stages register the product. With MUL_STAGE=1 the product is
//               combinational from the operand register.
// Ports       : clk, rst_n (async, active-low)
//               i_en      - advance; 0 holds every register
//               i_clr     - synchronous clear, overrides i_en
//               i_a/i_b   - operands, i_valid/i_tag travel alongside them
//               o_prod    - product, o_valid/o_tag aligned to it
//               o_busy    - any valid bit inside the pipe
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pe_mult_pipe #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int MUL_STAGE = 2,
    parameter int SIGNED    = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_en,
    input  logic                       i_clr,
    input  logic [WIDTH_A-1:0]         i_a,
    input  logic [WIDTH_B-1:0]         i_b,
    input  logic                       i_valid,
    input  logic                       i_tag,
    output logic [WIDTH_A+WIDTH_B-1:0] o_prod,
    output logic                       o_valid,
    output logic                       o_tag,
    output logic                       o_busy
);

    localparam int c_WP = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] r_a;
    logic [WIDTH_B-1:0] r_b;
    logic               r_v;
    logic               r_t;
    logic [c_WP-1:0]    w_mul;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= 1'b0;
            r_t <= 1'b0;
        end else if (i_clr) begin
            r_a <= '0;
            r_b <= '0;
            r_v <= 1'b0;
            r_t <= 1'b0;
        end else if (i_en) begin
            r_a <= i_a;
            r_b <= i_b;
            r_v <= i_valid;
            r_t <= i_tag;
        end
    end

    if (SIGNED != 0) begin : g_smul
        assign w_mul = $signed(r_a) * $signed(r_b);
    end else begin : g_umul
        assign w_mul = c_WP'(r_a) * c_WP'(r_b);
    end

    if (MUL_STAGE <= 1) begin : g_comb_out
        assign o_prod  = w_mul;
        assign o_valid = r_v;
        assign o_tag   = r_t;
        assign o_busy  = r_v;
    end else begin : g_prod_regs
        localparam int c_NP = MUL_STAGE - 1;
        logic [c_WP-1:0] r_p [c_NP];
        logic [c_NP-1:0] r_pv;
        logic [c_NP-1:0] r_pt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < c_NP; i++) r_p[i] <= '0;
                r_pv <= '0;
                r_pt <= '0;
            end else if (i_clr) begin
                for (int i = 0; i < c_NP; i++) r_p[i] <= '0;
                r_pv <= '0;
                r_pt <= '0;
            end else if (i_en) begin
                r_p[0]  <= w_mul;
                r_pv[0] <= r_v;
                r_pt[0] <= r_t;
                for (int i = 1; i < c_NP; i++) begin
                    r_p[i]  <= r_p[i-1];
                    r_pv[i] <= r_pv[i-1];
                    r_pt[i] <= r_pt[i-1];
                end
            end
        end

        assign o_prod  = r_p[c_NP-1];
        assign o_valid = r_pv[c_NP-1];
        assign o_tag   = r_pt[c_NP-1];
        assign o_busy  = r_v | (|r_pv);
    end

endmodule

`default_nettype wire

// File: rtl/processing_element_ms.sv
// ============================================================================
// Module      : processing_element_ms
// Description : Systolic processing element with run-time dataflow mode:
//               output-stationary (OS, mode=0) or weight-stationary (WS,
//               mode=1). act flows east, wei flows south, partial sums or
//               drained OS results flow along the MAC chain.
// Ports       : clk, rst_n (async, active-low), mode, pipeline_en, reg_clear
//               act/act_valid, wei/wei_valid, preload, c_switch, cscan_en,
//               MAC_IN/MAC_in_valid  -> inputs
//               act_out/act_valid_out, wei_out/wei_valid_out, c_switch_out,
//               MAC_out/MAC_valid_out, busy -> outputs
// Options     : `define PE_MAC_SATURATE_EN makes the accumulate/psum adder
//               saturate instead of wrapping modulo 2^WIDTH_MAC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module processing_element_ms
    import pe_ms_pkg::*;
#(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int WIDTH_MAC = 48,
    parameter int MUL_STAGE = 2,
    parameter int SIGNED    = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 pipeline_en,
    input  logic                 reg_clear,
    input  logic [WIDTH_A-1:0]   act,
    input  logic                 act_valid,
    input  logic [WIDTH_B-1:0]   wei,
    input  logic                 wei_valid,
    input  logic                 preload,
    input  logic                 c_switch,
    input  logic                 cscan_en,
    input  logic [WIDTH_MAC-1:0] MAC_IN,
    input  logic                 MAC_in_valid,
    output logic [WIDTH_A-1:0]   act_out,
    output logic                 act_valid_out,
    output logic [WIDTH_B-1:0]   wei_out,
    output logic                 wei_valid_out,
    output logic                 c_switch_out,
    output logic [WIDTH_MAC-1:0] MAC_out,
    output logic                 MAC_valid_out,
    output logic                 busy
);

    localparam int c_WP = WIDTH_A + WIDTH_B;

    pe_state_t            r_state;
    pe_state_t            w_state_nxt;
    logic [WIDTH_B-1:0]   r_wstat;
    logic [WIDTH_A-1:0]   r_act_out;
    logic                 r_act_v;
    logic [WIDTH_B-1:0]   r_wei_out;
    logic                 r_wei_v;
    logic                 r_csw_out;
    logic [WIDTH_MAC-1:0] r_acc;
    logic [WIDTH_MAC-1:0] r_shadow;
    logic                 r_shadow_v;
    logic [WIDTH_MAC-1:0] r_psum;
    logic                 r_psum_v;

    logic                 w_ws_state;
    logic                 w_eff_ws;
    logic                 w_issue;
    logic [WIDTH_B-1:0]   w_b;
    logic [c_WP-1:0]      w_prod;
    logic                 w_prod_valid;
    logic                 w_prod_tag;
    logic                 w_pipe_busy;
    logic [WIDTH_MAC-1:0] w_prod_ext;
    logic [WIDTH_MAC-1:0] w_mac_in_al;
    logic                 w_land_os;
    logic                 w_land_ws;
    logic [WIDTH_MAC-1:0] w_acc_add;
    logic [WIDTH_MAC-1:0] w_acc_sum;
    logic [WIDTH_MAC-1:0] w_psum_add;

    // ------------------------------------------------------------------
    // Mode resolution: in IDLE the mode pin decides, elsewhere the state.
    // ------------------------------------------------------------------
    assign w_ws_state = (r_state == c_ST_WS_LOAD) || (r_state == c_ST_WS_RUN);
    assign w_eff_ws   = w_ws_state || ((r_state == c_ST_IDLE) && (mode == c_MODE_WS));
    assign w_issue    = w_eff_ws ? act_valid : (act_valid & wei_valid);
    // The operand register samples r_wstat before a concurrent preload lands,
    // so an act arriving with preload still multiplies by the old weight.
    assign w_b        = w_eff_ws ? r_wstat : wei;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if ((mode == c_MODE_OS) && act_valid && wei_valid) begin
                    w_state_nxt = c_ST_OS_RUN;
                end else if ((mode == c_MODE_WS) && preload) begin
                    w_state_nxt = c_ST_WS_LOAD;
                end
            end
            c_ST_WS_LOAD: w_state_nxt = c_ST_WS_RUN;
            c_ST_WS_RUN:  if (preload) w_state_nxt = c_ST_WS_LOAD;
            c_ST_OS_RUN:  w_state_nxt = c_ST_OS_RUN;
            default:      w_state_nxt = c_ST_IDLE;
        endcase
    end

    // The tag records which datapath issued the product, so it lands in the
    // right accumulator even if the mode pin moves while IDLE.
    pe_mult_pipe #(
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B),
        .MUL_STAGE (MUL_STAGE),
        .SIGNED    (SIGNED)
    ) u_mult (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (pipeline_en),
        .i_clr   (reg_clear),
        .i_a     (act),
        .i_b     (w_b),
        .i_valid (w_issue),
        .i_tag   (w_eff_ws),
        .o_prod  (w_prod),
        .o_valid (w_prod_valid),
        .o_tag   (w_prod_tag),
        .o_busy  (w_pipe_busy)
    );

    if (SIGNED != 0) begin : g_sext
        assign w_prod_ext = WIDTH_MAC'($signed(w_prod));
    end else begin : g_zext
        assign w_prod_ext = WIDTH_MAC'(w_prod);
    end

    // Upstream partial sum is delayed so it meets the product of the act
    // that was sampled one cycle earlier.
    if (MUL_STAGE <= 1) begin : g_mac_dly_none
        assign w_mac_in_al = MAC_IN;
    end else begin : g_mac_dly
        localparam int c_ND = MUL_STAGE - 1;
        logic [WIDTH_MAC-1:0] r_dly [c_ND];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < c_ND; i++) r_dly[i] <= '0;
            end else if (reg_clear) begin
                for (int i = 0; i < c_ND; i++) r_dly[i] <= '0;
            end else if (pipeline_en) begin
                r_dly[0] <= MAC_IN;
                for (int i = 1; i < c_ND; i++) r_dly[i] <= r_dly[i-1];
            end
        end

        assign w_mac_in_al = r_dly[c_ND-1];
    end

    assign w_land_os = w_prod_valid && (w_prod_tag == c_MODE_OS);
    assign w_land_ws = w_prod_valid && (w_prod_tag == c_MODE_WS);

`ifdef PE_MAC_SATURATE_EN
    assign w_acc_add  = WIDTH_MAC'(sat_add(c_SAT_MAXW'(r_acc), c_SAT_MAXW'(w_prod_ext),
                                           WIDTH_MAC, SIGNED != 0));
    assign w_psum_add = WIDTH_MAC'(sat_add(c_SAT_MAXW'(w_mac_in_al), c_SAT_MAXW'(w_prod_ext),
                                           WIDTH_MAC, SIGNED != 0));
`else
    assign w_acc_add  = r_acc + w_prod_ext;
    assign w_psum_add = w_mac_in_al + w_prod_ext;
`endif

    // Accumulator value including any product landing this edge; this is
    // what c_switch drains so no in-flight product is lost.
    assign w_acc_sum = w_land_os ? w_acc_add : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_wstat    <= '0;
            r_act_out  <= '0;
            r_act_v    <= 1'b0;
            r_wei_out  <= '0;
            r_wei_v    <= 1'b0;
            r_csw_out  <= 1'b0;
            r_acc      <= '0;
            r_shadow   <= '0;
            r_shadow_v <= 1'b0;
            r_psum     <= '0;
            r_psum_v   <= 1'b0;
        end else if (reg_clear) begin
            r_state    <= c_ST_IDLE;
            r_wstat    <= '0;
            r_act_out  <= '0;
            r_act_v    <= 1'b0;
            r_wei_out  <= '0;
            r_wei_v    <= 1'b0;
            r_csw_out  <= 1'b0;
            r_acc      <= '0;
            r_shadow   <= '0;
            r_shadow_v <= 1'b0;
            r_psum     <= '0;
            r_psum_v   <= 1'b0;
        end else if (pipeline_en) begin
            r_state   <= w_state_nxt;
            r_act_out <= act;
            r_act_v   <= act_valid;
            r_wei_out <= wei;
            r_wei_v   <= wei_valid;
            r_csw_out <= c_switch;

            if (w_eff_ws && preload) r_wstat <= wei;

            // OS drain: c_switch has priority over a concurrent scan shift.
            if (!w_ws_state && c_switch) begin
                r_shadow   <= w_acc_sum;
                r_shadow_v <= 1'b1;
                r_acc      <= '0;
            end else begin
                r_acc <= w_acc_sum;
                if (!w_ws_state && cscan_en) begin
                    r_shadow   <= MAC_IN;
                    r_shadow_v <= MAC_in_valid;
                end
            end

            if (w_land_ws) r_psum <= w_psum_add;
            r_psum_v <= w_land_ws;
        end
    end

    assign act_out       = r_act_out;
    assign act_valid_out = r_act_v;
    assign wei_out       = r_wei_out;
    assign wei_valid_out = r_wei_v;
    assign c_switch_out  = r_csw_out;
    assign MAC_out       = w_ws_state ? r_psum : r_shadow;
    assign MAC_valid_out = w_ws_state ? r_psum_v : r_shadow_v;
    assign busy          = (r_state != c_ST_IDLE) || w_pipe_busy;

endmodule

`default_nettype wire

// File: tb/tb_processing_element_ms.sv
// ============================================================================
// Module      : tb_processing_element_ms
// Description : Directed self-checking bench for processing_element_ms with
//               default parameters (16/16/48, MUL_STAGE=2, unsigned).
//               Overflow expectation follows PE_MAC_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_processing_element_ms;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic        pipeline_en;
    logic        reg_clear;
    logic [15:0] act;
    logic        act_valid;
    logic [15:0] wei;
    logic        wei_valid;
    logic        preload;
    logic        c_switch;
    logic        cscan_en;
    logic [47:0] MAC_IN;
    logic        MAC_in_valid;
    logic [15:0] act_out;
    logic        act_valid_out;
    logic [15:0] wei_out;
    logic        wei_valid_out;
    logic        c_switch_out;
    logic [47:0] MAC_out;
    logic        MAC_valid_out;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    processing_element_ms dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .pipeline_en   (pipeline_en),
        .reg_clear     (reg_clear),
        .act           (act),
        .act_valid     (act_valid),
        .wei           (wei),
        .wei_valid     (wei_valid),
        .preload       (preload),
        .c_switch      (c_switch),
        .cscan_en      (cscan_en),
        .MAC_IN        (MAC_IN),
        .MAC_in_valid  (MAC_in_valid),
        .act_out       (act_out),
        .act_valid_out (act_valid_out),
        .wei_out       (wei_out),
        .wei_valid_out (wei_valid_out),
        .c_switch_out  (c_switch_out),
        .MAC_out       (MAC_out),
        .MAC_valid_out (MAC_valid_out),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [47:0] ovf_exp;
        rst_n = 1'b0; mode = 1'b0; pipeline_en = 1'b1; reg_clear = 1'b0;
        act = '0; act_valid = 1'b0; wei = '0; wei_valid = 1'b0;
        preload = 1'b0; c_switch = 1'b0; cscan_en = 1'b0;
        MAC_IN = '0; MAC_in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // ---------------- reset state ----------------
        check("rst_mac_out",   64'(MAC_out), 64'h0);
        check("rst_mac_valid", 64'(MAC_valid_out), 64'h0);
        check("rst_act_out",   64'(act_out), 64'h0);
        check("rst_busy",      64'(busy), 64'h0);
        check("rst_csw_out",   64'(c_switch_out), 64'h0);

        // ---------------- OS accumulate 1..4 x 2 ----------------
        mode = 1'b0; wei = 16'd2; wei_valid = 1'b1; act_valid = 1'b1;
        act = 16'd1; tick();
        check("os_act_fwd",  64'(act_out), 64'h1);
        check("os_busy",     64'(busy), 64'h1);
        act = 16'd2; tick();
        act = 16'd3; tick();
        act = 16'd4; tick();
        act_valid = 1'b0; wei_valid = 1'b0; tick();
        c_switch = 1'b1; tick();
        c_switch = 1'b0;
        check("os_drain_val",   64'(MAC_out), 64'h14);
        check("os_drain_valid", 64'(MAC_valid_out), 64'h1);
        check("os_csw_out",     64'(c_switch_out), 64'h1);

        // Fresh accumulation from zero: 3*2
        act = 16'd3; wei = 16'd2; act_valid = 1'b1; wei_valid = 1'b1; tick();
        act_valid = 1'b0; wei_valid = 1'b0;
        check("os_csw_pulse", 64'(c_switch_out), 64'h0);
        tick(); tick();

        // ---------------- OS scan ----------------
        MAC_IN = 48'hABC; MAC_in_valid = 1'b1; cscan_en = 1'b1; tick();
        cscan_en = 1'b0; MAC_in_valid = 1'b0;
        check("scan_val",   64'(MAC_out), 64'hABC);
        check("scan_valid", 64'(MAC_valid_out), 64'h1);
        MAC_IN = 48'h555; MAC_in_valid = 1'b1; cscan_en = 1'b1; c_switch = 1'b1; tick();
        cscan_en = 1'b0; c_switch = 1'b0; MAC_in_valid = 1'b0;
        check("cswitch_wins", 64'(MAC_out), 64'h6);
        check("os_run_busy",  64'(busy), 64'h1);

        // ---------------- async reset mid-OS ----------------
        act = 16'd1; wei = 16'd2; act_valid = 1'b1; wei_valid = 1'b1; tick();
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_mac_out",   64'(MAC_out), 64'h0);
        check("arst_mac_valid", 64'(MAC_valid_out), 64'h0);
        check("arst_act_out",   64'(act_out), 64'h0);
        check("arst_wei_out",   64'(wei_out), 64'h0);
        check("arst_busy",      64'(busy), 64'h0);
        act_valid = 1'b0; wei_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        check("arst_no_result", 64'(MAC_valid_out), 64'h0);
        check("arst_idle",      64'(busy), 64'h0);

        // ---------------- stall mid-OS stream ----------------
        wei = 16'd2; wei_valid = 1'b1; act_valid = 1'b1;
        act = 16'd1; tick();
        act = 16'd2; tick();
        pipeline_en = 1'b0; act = 16'd3; tick();
        check("stall_act_frozen", 64'(act_out), 64'h2);
        tick(); tick();
        check("stall_act_frozen3", 64'(act_out), 64'h2);
        check("stall_busy",        64'(busy), 64'h1);
        pipeline_en = 1'b1; tick();
        act = 16'd4; tick();
        act_valid = 1'b0; wei_valid = 1'b0; tick();
        c_switch = 1'b1; tick();
        c_switch = 1'b0;
        check("stall_drain", 64'(MAC_out), 64'h14);

        // ---------------- reg_clear ----------------
        reg_clear = 1'b1; tick();
        reg_clear = 1'b0;
        check("clr_mac_out",   64'(MAC_out), 64'h0);
        check("clr_mac_valid", 64'(MAC_valid_out), 64'h0);
        check("clr_busy",      64'(busy), 64'h0);

        // ---------------- WS preload and stream ----------------
        mode = 1'b1; MAC_IN = 48'd100; MAC_in_valid = 1'b1;
        preload = 1'b1; wei = 16'd3; wei_valid = 1'b1; tick();
        preload = 1'b0; wei_valid = 1'b0;
        check("ws_wei_fwd",   64'(wei_out), 64'h3);
        check("ws_wei_v_fwd", 64'(wei_valid_out), 64'h1);
        act = 16'd5; act_valid = 1'b1; tick();
        act_valid = 1'b0; tick();
        check("ws_not_yet", 64'(MAC_valid_out), 64'h0);
        tick();
        check("ws_psum",       64'(MAC_out), 64'd115);
        check("ws_psum_valid", 64'(MAC_valid_out), 64'h1);

        preload = 1'b1; wei = 16'd7; act = 16'd5; act_valid = 1'b1; tick();
        preload = 1'b0; tick();
        act_valid = 1'b0; tick();
        check("ws_old_weight", 64'(MAC_out), 64'd115);
        tick();
        check("ws_new_weight", 64'(MAC_out), 64'd135);
        check("ws_new_valid",  64'(MAC_valid_out), 64'h1);
        tick();
        check("ws_valid_drop", 64'(MAC_valid_out), 64'h0);

        // ---------------- WS unsigned overflow ----------------
        reg_clear = 1'b1; tick();
        reg_clear = 1'b0;
        MAC_IN = 48'hFFFF_FFFF_FFFE; MAC_in_valid = 1'b1;
        preload = 1'b1; wei = 16'd2; tick();
        preload = 1'b0;
        act = 16'd2; act_valid = 1'b1; tick();
        act_valid = 1'b0; tick(); tick();
`ifdef PE_MAC_SATURATE_EN
        ovf_exp = 48'hFFFF_FFFF_FFFF;
`else
        ovf_exp = 48'h0000_0000_0002;
`endif
        check("ovf_val",   64'(MAC_out), 64'(ovf_exp));
        check("ovf_valid", 64'(MAC_valid_out), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
